// File: rtl/run_ctrl.sv
// Run controller: starts one processor program, counts its RUN cycles,
// times it out, and arbitrates the shared data memory between host and core.
module run_ctrl #(
    parameter logic [15:0] TMO = 16'd4000,
    parameter int          AW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [1:0]    prog_sel,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdat,
    output logic          host_gnt,
    output logic [7:0]    host_rdat,
    output logic          core_start,
    output logic [1:0]    core_prog,
    input  logic          core_done,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [7:0]    core_wdat,
    output logic [7:0]    core_rdat,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdat,
    input  logic [7:0]    mem_rdat,
    output logic          busy,
    output logic [1:0]    status,
    output logic [15:0]   cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] TLIM = TMO - 16'd1;

    logic [1:0]  state;
    logic [15:0] cyc_inc;
    logic        tmo_hit;

    assign cyc_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
    assign tmo_hit = (cycles == TLIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            core_prog <= 2'd0;
            status    <= 2'd0;
            cycles    <= 16'd0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        state     <= S_START;
                        core_prog <= prog_sel;
                        cycles    <= 16'd0;
                    end
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    // the completing cycle is counted too
                    cycles <= cyc_inc;
                    if (core_done) begin
                        state  <= S_DONE;
                        status <= 2'd1;
                    end else if (tmo_hit) begin
                        state  <= S_DONE;
                        status <= 2'd2;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state == S_START) || (state == S_RUN);
    assign core_start = (state == S_START);

    // core owns the memory while busy; the other side's writes are dropped
    assign host_gnt  = host_req && !busy;
    assign host_rdat = host_gnt ? mem_rdat : 8'd0;
    assign core_rdat = busy ? mem_rdat : 8'd0;
    assign mem_we    = busy ? core_we : (host_req && host_we);
    assign mem_addr  = busy ? core_addr : host_addr;
    assign mem_wdat  = busy ? core_wdat : host_wdat;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: two instances (long and short timeout)
// share stimulus and are checked every cycle against a run-level model.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [1:0] prog_sel = 2'd0;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = 8'd0;
    logic [7:0] host_wdat = 8'd0;
    logic       core_done = 1'b0;
    logic       core_we = 1'b0;
    logic [7:0] core_addr = 8'd0;
    logic [7:0] core_wdat = 8'd0;

    logic        a_gnt, b_gnt, a_start, b_start, a_busy, b_busy;
    logic        a_mwe, b_mwe;
    logic [1:0]  a_prog, b_prog, a_status, b_status;
    logic [7:0]  a_hrd, b_hrd, a_crd, b_crd, a_maddr, b_maddr;
    logic [7:0]  a_mwd, b_mwd, a_mrd, b_mrd;
    logic [15:0] a_cyc, b_cyc;

    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int tmo [2] = '{60, 16};
    bit m_start [2];
    bit m_running [2];
    int m_n [2];
    int m_status [2];
    int m_prog [2];

    always #5 clk = ~clk;

    assign a_mrd = mem[a_maddr];
    assign b_mrd = mem[b_maddr];

    always @(posedge clk) begin
        if (a_mwe) mem[a_maddr] <= a_mwd;
    end

    run_ctrl #(.TMO(16'd60), .AW(8)) u_a (
        .clk(clk), .reset(reset), .run(run), .prog_sel(prog_sel),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdat(host_wdat), .host_gnt(a_gnt), .host_rdat(a_hrd),
        .core_start(a_start), .core_prog(a_prog), .core_done(core_done),
        .core_we(core_we), .core_addr(core_addr), .core_wdat(core_wdat),
        .core_rdat(a_crd), .mem_we(a_mwe), .mem_addr(a_maddr),
        .mem_wdat(a_mwd), .mem_rdat(a_mrd), .busy(a_busy),
        .status(a_status), .cycles(a_cyc)
    );

    run_ctrl #(.TMO(16'd16), .AW(8)) u_b (
        .clk(clk), .reset(reset), .run(run), .prog_sel(prog_sel),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdat(host_wdat), .host_gnt(b_gnt), .host_rdat(b_hrd),
        .core_start(b_start), .core_prog(b_prog), .core_done(core_done),
        .core_we(core_we), .core_addr(core_addr), .core_wdat(core_wdat),
        .core_rdat(b_crd), .mem_we(b_mwe), .mem_addr(b_maddr),
        .mem_wdat(b_mwd), .mem_rdat(b_mrd), .busy(b_busy),
        .status(b_status), .cycles(b_cyc)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: a run is "starting" for one cycle, then "running"
    // for N counted cycles until done or the N-th cycle reaches the limit.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_start[i] = 1'b0;
                m_running[i] = 1'b0;
                m_n[i] = 0;
                m_status[i] = 0;
                m_prog[i] = 0;
            end else if (m_start[i]) begin
                m_start[i] = 1'b0;
                m_running[i] = 1'b1;
            end else if (m_running[i]) begin
                m_n[i] = (m_n[i] < 65535) ? m_n[i] + 1 : 65535;
                if (core_done) begin
                    m_running[i] = 1'b0;
                    m_status[i] = 1;
                end else if (m_n[i] == tmo[i]) begin
                    m_running[i] = 1'b0;
                    m_status[i] = 2;
                end
            end else if (run) begin
                m_start[i] = 1'b1;
                m_prog[i] = int'(prog_sel);
                m_n[i] = 0;
            end
        end
    end

    task automatic check_inst(input int i, input logic gnt, input logic [7:0] hrd,
                              input logic st, input logic [1:0] prog,
                              input logic [7:0] crd, input logic mwe,
                              input logic [7:0] maddr, input logic [7:0] mwd,
                              input logic bsy, input logic [1:0] sts,
                              input logic [15:0] cyc);
        bit eb;
        bit eg;
        eb = m_start[i] || m_running[i];
        eg = host_req && !eb;
        chk($sformatf("busy%0d", i), bsy, eb);
        chk($sformatf("core_start%0d", i), st, m_start[i]);
        chk($sformatf("core_prog%0d", i), prog, m_prog[i]);
        chk($sformatf("status%0d", i), sts, m_status[i]);
        chk($sformatf("cycles%0d", i), cyc, m_n[i]);
        chk($sformatf("host_gnt%0d", i), gnt, eg);
        chk($sformatf("host_rdat%0d", i), hrd, eg ? mem[host_addr] : 8'd0);
        chk($sformatf("core_rdat%0d", i), crd, eb ? mem[core_addr] : 8'd0);
        chk($sformatf("mem_we%0d", i), mwe, eb ? core_we : (host_req && host_we));
        chk($sformatf("mem_addr%0d", i), maddr, eb ? core_addr : host_addr);
        chk($sformatf("mem_wdat%0d", i), mwd, eb ? core_wdat : host_wdat);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, a_gnt, a_hrd, a_start, a_prog, a_crd, a_mwe, a_maddr,
                       a_mwd, a_busy, a_status, a_cyc);
            check_inst(1, b_gnt, b_hrd, b_start, b_prog, b_crd, b_mwe, b_maddr,
                       b_mwd, b_busy, b_status, b_cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'd0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_start", a_start, 1'b0);
        chk("rst_status", a_status, 2'd0);
        chk("rst_cycles", a_cyc, 16'd0);
        reset = 1'b0;

        // host fills 0..32, then program 3 runs 50 cycles
        for (int k = 0; k <= 32; k++) begin
            host_req = 1'b1;
            host_we = 1'b1;
            host_addr = 8'(k);
            host_wdat = 8'(k) ^ 8'hA5;
            step();
        end
        host_req = 1'b0;
        host_we = 1'b0;
        run = 1'b1;
        prog_sel = 2'd3;
        step();
        run = 1'b0;
        chk("start_pulse", a_start, 1'b1);
        chk("prog_latched", a_prog, 2'd3);
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 8'd33;
        host_wdat = 8'hFF;
        step();
        chk("start_one_cycle", a_start, 1'b0);
        chk("host_denied", a_gnt, 1'b0);
        repeat (9) step();
        core_we = 1'b1;
        core_addr = 8'd33;
        core_wdat = 8'h05;
        step();
        core_we = 1'b0;
        repeat (39) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        host_req = 1'b0;
        host_we = 1'b0;
        chk("ok_status", a_status, 2'd1);
        chk("ok_cycles", a_cyc, 16'd50);
        chk("tmo16_status", b_status, 2'd2);
        chk("tmo16_cycles", b_cyc, 16'd16);
        host_req = 1'b1;
        host_addr = 8'd33;
        #1;
        chk("rd33", a_hrd, 8'h05);
        host_addr = 8'd0;
        #1;
        chk("rd0", a_hrd, 8'hA5);
        host_addr = 8'd32;
        #1;
        chk("rd32", a_hrd, 8'h85);
        step();

        // host write and run together from DONE, then reset mid-run
        host_we = 1'b1;
        host_addr = 8'd34;
        host_wdat = 8'h3C;
        run = 1'b1;
        prog_sel = 2'd1;
        #1;
        chk("same_cycle_gnt", a_gnt, 1'b1);
        step();
        host_req = 1'b0;
        host_we = 1'b0;
        run = 1'b0;
        chk("same_cycle_start", a_start, 1'b1);
        chk("prog1", a_prog, 2'd1);
        repeat (10) step();
        chk("mid_run_cycles", a_cyc, 16'd9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", a_busy, 1'b0);
        chk("abort_status", a_status, 2'd0);
        chk("abort_cycles", a_cyc, 16'd0);
        host_req = 1'b1;
        host_addr = 8'd34;
        #1;
        chk("abort_gnt", a_gnt, 1'b1);
        chk("rd34", a_hrd, 8'h3C);
        step();
        host_req = 1'b0;

        // done coincides with the short instance's last allowed cycle
        run = 1'b1;
        prog_sel = 2'd2;
        step();
        run = 1'b0;
        repeat (16) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("tie_status", b_status, 2'd1);
        chk("tie_cycles", b_cyc, 16'd16);
        chk("tie_a_status", a_status, 2'd1);

        // long instance times out at 60
        run = 1'b1;
        prog_sel = 2'd0;
        step();
        run = 1'b0;
        repeat (62) step();
        chk("tmo60_status", a_status, 2'd2);
        chk("tmo60_cycles", a_cyc, 16'd60);
        chk("tmo60_busy", a_busy, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter TMO, default 16'd4000: RUN-cycle limit before the run is aborted as a timeout.
REQ-002 Parameter AW, default 8: data-memory address width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  request to run one program; sampled only in IDLE or DONE.
REQ-006 prog_sel  input  2  program number; captured when run is accepted.
REQ-007 host_req, host_we  input  1 each  host memory access request and its write enable.
REQ-008 host_addr  input  AW  host memory address.
REQ-009 host_wdat  input  8  host memory write data.
REQ-010 host_gnt  output  1  host access accepted this cycle.
REQ-011 host_rdat  output  8  host read data.
REQ-012 core_start  output  1  one-cycle start/reset pulse to the processor.
REQ-013 core_prog  output  2  program number presented to the processor.
REQ-014 core_done  input  1  processor completion level.
REQ-015 core_we  input  1  processor memory write enable.
REQ-016 core_addr  input  AW  processor memory address.
REQ-017 core_wdat  input  8  processor memory write data.
REQ-018 core_rdat  output  8  processor read data.
REQ-019 mem_we  output  1  write enable to the shared data memory.
REQ-020 mem_addr  output  AW  address to the shared data memory.
REQ-021 mem_wdat  output  8  write data to the shared data memory.
REQ-022 mem_rdat  input  8  combinational read data from the shared data memory.
REQ-023 busy  output  1  high in START or RUN.
REQ-024 status  output  2  result of the last run: 0 = none, 1 = ok, 2 = timeout.
REQ-025 cycles  output  16  RUN-cycle count of the last or current run.

Function
REQ-026 The controller has four states, IDLE, START, RUN and DONE, and SHALL be a single FSM in exactly one of them.
REQ-027 IDLE or DONE with run=1 -> START; prog_sel is latched into core_prog; cycles clears to 0.
REQ-028 START lasts exactly one cycle, during which core_start=1; START -> RUN unconditionally.
REQ-029 In RUN, cycles increments by 1 every cycle and saturates at 16'hFFFF.
REQ-030 In RUN, core_done is sampled and is ignored in every other state.
REQ-031 RUN with core_done=1 -> DONE and status=1; the counted cycle includes the done cycle.
REQ-032 RUN with cycles==TMO-1 and core_done=0 -> DONE and status=2.
REQ-033 If core_done=1 and the timeout condition occur in the same cycle, status=1 (done wins).
REQ-034 Memory ownership: the host owns the memory in IDLE/DONE; the core owns it in START/RUN.
REQ-035 Memory mux: mem_we/mem_addr/mem_wdat come from the owner, mem_we is gated by the owner's request, and the non-owner's writes are dropped.
REQ-036 host_gnt = host_req AND (state is IDLE or DONE), combinational.
REQ-037 host_rdat = mem_rdat when host_gnt, else 0.
REQ-038 core_rdat = mem_rdat in START/RUN, else 0.
REQ-039 When host_req and run are both active in IDLE/DONE, the host access completes that cycle and START follows next cycle.
REQ-040 In START/RUN, host_req gets host_gnt=0 and the host holds its request; no request is queued.
REQ-041 DONE holds status, cycles and core_prog until the next accepted run.

Reset
REQ-042 On reset: state=IDLE, core_start=0, core_prog=0, busy=0, status=0, cycles=0; host_gnt then follows REQ-036.
REQ-043 Reset asserted in START or RUN aborts the run, drops core ownership on the next edge, and leaves status=0.
REQ-044 Reset has priority over run, core_done and the timeout condition.

Verification
REQ-045 Host writes addresses 0..32 in IDLE, then run with prog_sel=3; core_done at the 50th RUN cycle -> core_start high exactly one cycle, status=1, cycles=50, host writes land in memory.
REQ-046 Run with core_done never asserted and TMO=16 -> DONE after 16 RUN cycles, status=2, cycles=16.
REQ-047 host_req during RUN -> host_gnt=0 and no host write; core_we to address 33 writes 8'h05 -> host reads 8'h05 in DONE.
REQ-048 run and host_req (write addr 34) in the same IDLE cycle -> the write completes and START follows the next cycle.
REQ-049 Reset asserted mid-RUN at cycle 10 -> next cycle state=IDLE, busy=0, status=0, cycles=0, host_gnt available.
REQ-050 core_done and cycles==TMO-1 coincide -> status=1.
